// File: rtl/senal_evento_decoder.sv
// Turns the four level-toggle button lines into ordered press events.
// Events are queued in a show-ahead FIFO behind a valid/ready handshake.
module senal_evento_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Senal_Test,
    input  logic                         Senal_Energia,
    input  logic                         Senal_Medicina,
    input  logic                         Senal_Reset,
    input  logic                         evt_ready,
    input  logic                         ovf_clr,
    output logic                         evt_valid,
    output logic [1:0]                   evt_code,
    output logic [$clog2(FIFO_DEPTH):0]  pending,
    output logic                         overflow
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
    // evt_code holds steady while evt_valid is high and no transfer occurs.

    // Source bit index equals its event code: 0 Reset, 1 Test, 2 Medicina, 3 Energia.
    logic [3:0]    raw;
    logic [3:0]    sync_q [SYNC_STAGES];
    logic [3:0]    prev_q;
    logic [3:0]    change;
    logic [3:0]    pend_q;
    logic [3:0]    pend_d;
    logic [3:0]    clear_mask;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count_q;
    logic          pop;
    logic          push;
    logic          win_valid;
    logic          reset_win;
    logic          lost;
    logic [1:0]    win_code;

    assign raw       = {Senal_Energia, Senal_Medicina, Senal_Test, Senal_Reset};
    assign change    = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign evt_valid = (count_q != '0);
    assign evt_code  = mem_q[rd_ptr];
    assign pending   = count_q;

    always_comb begin
        win_valid = |pend_q;
        win_code  = 2'd0;
        if (pend_q[0])      win_code = 2'd0;
        else if (pend_q[1]) win_code = 2'd1;
        else if (pend_q[2]) win_code = 2'd2;
        else if (pend_q[3]) win_code = 2'd3;
        reset_win = pend_q[0];
        pop       = evt_valid && evt_ready;
        // A Reset winner always writes since it flushes the queue first.
        push      = win_valid && (reset_win || (count_q < DEPTH_C) || pop);
    end

    always_comb begin
        clear_mask = 4'b0000;
        if (push) begin
            if (reset_win) clear_mask = 4'b1111;
            else           clear_mask[win_code] = 1'b1;
        end
        pend_d = (pend_q & ~clear_mask) | change;
        lost   = |(change & pend_q & ~clear_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)  mem_q[i]  <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q   <= sync_q[SYNC_STAGES-1];
            pend_q   <= pend_d;
            overflow <= lost | (overflow & ~ovf_clr);

            if (push && reset_win) begin
                // Flush: the Reset code becomes the sole entry, any same-edge pop is moot.
                mem_q[wr_ptr] <= 2'd0;
                rd_ptr        <= wr_ptr;
                wr_ptr        <= wr_ptr + PW'(1);
                count_q       <= (PW+1)'(1);
            end else begin
                if (push) begin
                    mem_q[wr_ptr] <= win_code;
                    wr_ptr        <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + (PW+1)'(1);
                    2'b01:   count_q <= count_q - (PW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule
